// File: rtl/lcd_bus_pkg.sv
// Shared constants, enums and the HD44780 two-line address stepper for the LCD bus capture block.
package lcd_bus_pkg;

    localparam int LCD_COLS  = 16;
    localparam int LCD_CHARS = 2 * LCD_COLS;

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE0_LAST = 7'h27;
    localparam logic [6:0] LINE1_LAST = 7'h67;

    // Opcode masks; a command is classified by its highest set bit.
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPLAY = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } lcd_state_e;

    typedef enum logic {
        TGT_DDRAM = 1'b0,
        TGT_CGRAM = 1'b1
    } lcd_target_e;

    function automatic logic [6:0] step_addr(input logic [6:0] addr, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (addr == LINE0_LAST)      nxt = LINE1_BASE;
            else if (addr == LINE1_LAST) nxt = LINE0_BASE;
            else                         nxt = addr + 7'd1;
        end else begin
            if (addr == LINE0_BASE)      nxt = LINE1_LAST;
            else if (addr == LINE1_BASE) nxt = LINE0_LAST;
            else                         nxt = addr - 7'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_char_buffer.sv
// 2x16 character image with a single write port; resets to all spaces and
// exposes each line packed with column 0 in the top byte.
module lcd_char_buffer
    import lcd_bus_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [4:0]   wr_index,
    input  logic [7:0]   wr_byte,
    output logic [127:0] topline,
    output logic [127:0] bottomline
);

    logic [7:0] mem_q [LCD_CHARS];
    logic [7:0] mem_d [LCD_CHARS];

    always_comb begin
        for (int i = 0; i < LCD_CHARS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[wr_index] = wr_byte;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LCD_CHARS; i++) begin
            if (reset) mem_q[i] <= SPACE_CHAR;
            else       mem_q[i] <= mem_d[i];
        end
    end

    for (genvar c = 0; c < LCD_COLS; c++) begin : g_pack
        assign topline[127 - 8*c -: 8]    = mem_q[c];
        assign bottomline[127 - 8*c -: 8] = mem_q[c + LCD_COLS];
    end

endmodule

// File: rtl/lcd_bus_capture.sv
// Board-side responder for the 8-bit HD44780-style write bus: samples the bus,
// decodes commands and character writes, and keeps a 2x16 text image.
module lcd_bus_capture
    import lcd_bus_pkg::*;
#(
    parameter int CLEAR_CYCLES = 32
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         lcd_regsel,
    input  logic         lcd_read,
    input  logic         lcd_enable,
    input  logic [7:0]   lcd_data,
    output logic [127:0] topline,
    output logic [127:0] bottomline,
    output logic         display_on,
    output logic         busy,
    output logic         char_strobe,
    output logic         cmd_strobe,
    output logic         error,
    output lcd_state_e   state_dbg
);

    localparam int                CNT_W     = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CLR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CLR_CHARS = CNT_W'(LCD_CHARS);

    lcd_state_e       state_q, state_d;
    lcd_target_e      target_q, target_d;
    logic             enable_q, enable_d;
    logic             regsel_q, regsel_d;
    logic             read_q, read_d;
    logic [7:0]       data_q, data_d;
    logic [6:0]       addr_q, addr_d;
    logic             inc_q, inc_d;
    logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             display_on_q, display_on_d;
    logic             busy_q, busy_d;
    logic             char_strobe_q, char_strobe_d;
    logic             cmd_strobe_q, cmd_strobe_d;
    logic             error_q, error_d;

    logic             txn;
    logic             buf_we;
    logic [4:0]       buf_index;
    logic [7:0]       buf_byte;

    // char_strobe/cmd_strobe are one-cycle valid pulses with no ready: the
    // image and flags they refer to are already visible in the pulse cycle.
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        enable_d      = lcd_enable;
        regsel_d      = regsel_q;
        read_d        = read_q;
        data_d        = data_q;
        addr_d        = addr_q;
        inc_d         = inc_q;
        clr_cnt_d     = clr_cnt_q;
        display_on_d  = display_on_q;
        char_strobe_d = 1'b0;
        cmd_strobe_d  = 1'b0;
        error_d       = error_q;
        buf_we        = 1'b0;
        buf_index     = 5'd0;
        buf_byte      = SPACE_CHAR;
        txn           = enable_q && !lcd_enable;

        if (lcd_enable) begin
            regsel_d = lcd_regsel;
            read_d   = lcd_read;
            data_d   = lcd_data;
        end

        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q < CLR_CHARS) begin
                    buf_we    = 1'b1;
                    buf_index = clr_cnt_q[4:0];
                end
                if (clr_cnt_q == CLR_LAST) state_d = ST_IDLE;
                else                       clr_cnt_d = clr_cnt_q + CNT_W'(1);
                if (txn) error_d = 1'b1;
            end
            default: begin
                if (txn) begin
                    if (read_q) begin
                        error_d = 1'b1;
                    end else if (!regsel_q) begin
                        cmd_strobe_d = 1'b1;
                        if (|(data_q & CMD_DDRAM)) begin
                            addr_d   = data_q[6:0];
                            target_d = TGT_DDRAM;
                        end else if (|(data_q & CMD_CGRAM)) begin
                            target_d = TGT_CGRAM;
                        end else if (|(data_q & (CMD_FUNC | CMD_SHIFT))) begin
                            target_d = target_q;
                        end else if (|(data_q & CMD_DISPLAY)) begin
                            display_on_d = data_q[2];
                        end else if (|(data_q & CMD_ENTRY)) begin
                            inc_d = data_q[1];
                            if (data_q[0]) error_d = 1'b1;
                        end else if (|(data_q & CMD_HOME)) begin
                            addr_d = LINE0_BASE;
                        end else if (|(data_q & CMD_CLEAR)) begin
                            state_d   = ST_CLEAR;
                            clr_cnt_d = '0;
                            addr_d    = LINE0_BASE;
                            inc_d     = 1'b1;
                        end
                    end else begin
                        // The counter steps even when the byte lands nowhere.
                        addr_d = step_addr(addr_q, inc_q);
                        if (target_q == TGT_DDRAM &&
                            (addr_q[6:4] == 3'b000 || addr_q[6:4] == 3'b100)) begin
                            buf_we        = 1'b1;
                            buf_index     = {addr_q[6], addr_q[3:0]};
                            buf_byte      = data_q;
                            char_strobe_d = 1'b1;
                        end
                    end
                end
            end
        endcase

        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            target_q      <= TGT_DDRAM;
            enable_q      <= 1'b0;
            regsel_q      <= 1'b0;
            read_q        <= 1'b0;
            data_q        <= 8'h00;
            addr_q        <= LINE0_BASE;
            inc_q         <= 1'b1;
            clr_cnt_q     <= '0;
            display_on_q  <= 1'b0;
            busy_q        <= 1'b0;
            char_strobe_q <= 1'b0;
            cmd_strobe_q  <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            enable_q      <= enable_d;
            regsel_q      <= regsel_d;
            read_q        <= read_d;
            data_q        <= data_d;
            addr_q        <= addr_d;
            inc_q         <= inc_d;
            clr_cnt_q     <= clr_cnt_d;
            display_on_q  <= display_on_d;
            busy_q        <= busy_d;
            char_strobe_q <= char_strobe_d;
            cmd_strobe_q  <= cmd_strobe_d;
            error_q       <= error_d;
        end
    end

    lcd_char_buffer u_buffer (
        .clk        (clk),
        .reset      (reset),
        .we         (buf_we),
        .wr_index   (buf_index),
        .wr_byte    (buf_byte),
        .topline    (topline),
        .bottomline (bottomline)
    );

    assign display_on  = display_on_q;
    assign busy        = busy_q;
    assign char_strobe = char_strobe_q;
    assign cmd_strobe  = cmd_strobe_q;
    assign error       = error_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_lcd_bus_capture.sv
// Self-checking bench for lcd_bus_capture: directed bus writes, strobe scoreboard
// and direct checks of image, busy length and sticky error.
module tb_lcd_bus_capture;
    import lcd_bus_pkg::*;

    localparam int W = 260;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         lcd_regsel = 1'b0;
    logic         lcd_read = 1'b0;
    logic         lcd_enable = 1'b0;
    logic [7:0]   lcd_data = 8'h00;
    logic [127:0] topline, bottomline;
    logic         display_on, busy, char_strobe, cmd_strobe, error;
    lcd_state_e   state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_act, mon_exp;

    logic [127:0] m_top, m_bot;
    logic         m_err, m_disp;
    int           busy_run = 0;
    int           busy_len = 0;

    localparam logic [127:0] SPACES = {16{8'h20}};

    lcd_bus_capture #(.CLEAR_CYCLES(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_regsel (lcd_regsel),
        .lcd_read   (lcd_read),
        .lcd_enable (lcd_enable),
        .lcd_data   (lcd_data),
        .topline    (topline),
        .bottomline (bottomline),
        .display_on (display_on),
        .busy       (busy),
        .char_strobe(char_strobe),
        .cmd_strobe (cmd_strobe),
        .error      (error),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_top  = SPACES;
        m_bot  = SPACES;
        m_err  = 1'b0;
        m_disp = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset      = 1'b1;
        lcd_enable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_top"},   topline,     SPACES);
        chk({tag, "_bot"},   bottomline,  SPACES);
        chk({tag, "_disp"},  display_on,  1'b0);
        chk({tag, "_busy"},  busy,        1'b0);
        chk({tag, "_chs"},   char_strobe, 1'b0);
        chk({tag, "_cms"},   cmd_strobe,  1'b0);
        chk({tag, "_err"},   error,       1'b0);
        chk({tag, "_state"}, state_dbg,   ST_IDLE);
    endtask

    // Drivers
    task automatic bus_write(input logic rs, input logic rd, input logic [7:0] d);
        @(posedge clk); #1;
        lcd_regsel = rs;
        lcd_read   = rd;
        lcd_data   = d;
        lcd_enable = 1'b1;
        @(posedge clk); #1;
        lcd_enable = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] kind);
        exp_q.push_back({kind, m_err, m_disp, m_top, m_bot});
    endtask

    task automatic set_char(input int line, input int col, input logic [7:0] ch);
        if (line == 0) m_top[127 - 8*col -: 8] = ch;
        else           m_bot[127 - 8*col -: 8] = ch;
    endtask

    task automatic send_cmd(input logic [7:0] d);
        push_exp(2'b10);
        bus_write(1'b0, 1'b0, d);
    endtask

    // hit=0 means the byte is expected to be discarded with no strobe.
    task automatic send_char(input logic [7:0] d, input bit hit, input int line, input int col);
        if (hit) begin
            set_char(line, col, d);
            push_exp(2'b01);
        end
        bus_write(1'b1, 1'b0, d);
    endtask

    task automatic write_line(input logic [127:0] text, input int line);
        logic [7:0] ch;
        for (int c = 0; c < 16; c++) begin
            ch = text[127 - 8*c -: 8];
            send_char(ch, 1'b1, line, c);
        end
    endtask

    // Scoreboard monitor and busy-run measurement
    always @(negedge clk) begin
        if (char_strobe || cmd_strobe) begin
            mon_act = {cmd_strobe, char_strobe, error, display_on, topline, bottomline};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got %h expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL strobe_record: got %h expected %h", mon_act, mon_exp);
                end
            end
        end
        if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
    end

    logic [127:0] tmp_top, tmp_bot;

    initial begin
        model_reset();
        do_reset();
        check_reset_state("reset0");

        // Two full lines of text
        send_cmd(8'h80);
        write_line("Welcome to Simon", 0);
        send_cmd(8'hC0);
        write_line("Press GRN button", 1);
        drain();
        @(negedge clk);
        chk("t1_top", topline, 128'("Welcome to Simon"));
        chk("t1_bot", bottomline, 128'("Press GRN button"));
        chk("t1_err", error, 1'b0);

        // Clear, with a transaction arriving while busy
        busy_len = 0;
        send_cmd(8'h01);
        m_top = SPACES;
        m_bot = SPACES;
        bus_write(1'b0, 1'b0, 8'h80);
        m_err = 1'b1;
        for (int i = 0; i < 200 && busy_len == 0; i++) @(negedge clk);
        chk("t2_busy_len", busy_len, 32);
        @(negedge clk);
        chk("t2_busy_low", busy, 1'b0);
        chk("t2_top", topline, SPACES);
        chk("t2_bot", bottomline, SPACES);
        chk("t2_err", error, 1'b1);

        // Line-0 end wraps to line 1
        drain();
        do_reset();
        send_cmd(8'hA7);
        send_char("A", 1'b0, 0, 0);
        send_char("B", 1'b1, 1, 0);

        // Decrement mode wraps 0x00 to 0x67
        send_cmd(8'h04);
        send_cmd(8'h80);
        send_char("X", 1'b1, 0, 0);
        send_char("Y", 1'b0, 0, 0);

        // CGRAM write leaves image alone; display control
        send_cmd(8'h40);
        send_char(8'h55, 1'b0, 0, 0);
        m_disp = 1'b1;
        send_cmd(8'h0C);
        drain();
        tmp_top = SPACES;
        tmp_top[127:120] = "X";
        tmp_bot = SPACES;
        tmp_bot[127:120] = "B";
        @(negedge clk);
        chk("t5_top", topline, tmp_top);
        chk("t5_bot", bottomline, tmp_bot);
        chk("t5_disp", display_on, 1'b1);
        chk("t5_err", error, 1'b0);

        // Read transaction sets error
        drain();
        do_reset();
        bus_write(1'b0, 1'b1, 8'h80);
        drain();
        @(negedge clk);
        chk("t6_read_err", error, 1'b1);
        do_reset();
        @(negedge clk);
        chk("t6_err_cleared", error, 1'b0);

        // Entry mode with shift sets sticky error
        m_err = 1'b1;
        send_cmd(8'h05);
        send_cmd(8'h80);
        send_char("Q", 1'b1, 0, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t6_err_sticky", error, 1'b1);
        chk("t6_q_top", topline[127:120], 8'h51);

        // Reset asserted while enable is high; the later fall is not a transaction
        @(posedge clk); #1;
        lcd_regsel = 1'b1;
        lcd_read   = 1'b0;
        lcd_data   = "R";
        lcd_enable = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        lcd_enable = 1'b0;
        model_reset();
        check_reset_state("mid_reset_a");
        check_reset_state("mid_reset_b");
        drain();
        check_reset_state("mid_reset_c");

        chk("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lcd_bus_capture.md
# lcd_bus_capture

Write-side responder for the 8-bit HD44780-style LCD bus that `lcd_string` drives (`lcd_regsel`, `lcd_read`, `lcd_enable`, `lcd_data`). It decodes each bus transaction into commands and character writes, and maintains a 2x16 character image. The image is presented as `topline`/`bottomline` in the same packing `lcd_string` consumes. It sits on the board-side of the LCD pins in simulation and in on-chip debug builds, so the Simon top-level's displayed text can be observed and checked without a physical panel.

## Interface
- `CLEAR_CYCLES`, default 32: cycles spent clearing, one character per cycle. Must be ≥32.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `lcd_regsel`  in  1  0 = command, 1 = data.
- `lcd_read`  in  1  1 = read cycle. Not supported; flagged.
- `lcd_enable`  in  1  transaction strobe; a transaction completes on its falling edge.
- `lcd_data`  in  8  bus byte.
- `topline`  out  128  line 0; column 0 in bits [127:120].
- `bottomline`  out  128  line 1; same packing as `topline`.
- `display_on`  out  1  last display-control D bit.
- `busy`  out  1  high while clearing.
- `char_strobe`  out  1  one-cycle pulse per accepted DDRAM data write.
- `cmd_strobe`  out  1  one-cycle pulse per accepted command.
- `error`  out  1  sticky; cleared only by `reset`.

## Operation
- **Sampling:** `lcd_regsel`, `lcd_read` and `lcd_data` are registered every cycle while `lcd_enable` is high. A transaction is the cycle in which registered `enable_q`=1 and `lcd_enable`=0, and it uses the last sampled values.
- **Read transactions** (`lcd_read`=1): dropped and `error` is set.
- **Commands**, decoded by the highest set bit of the byte:
  - 0x01 clear: enter CLEAR, addr←0x00, increment mode←1.
  - 0x02/0x03 home: addr←0x00.
  - 0x04–0x07 entry mode: inc←bit1. If bit0 (S) is 1, set `error`; display shift is unsupported.
  - 0x08–0x0F display control: `display_on`←bit2. Cursor and blink bits are ignored.
  - 0x10–0x3F shift / function set: accepted with no effect.
  - 0x40–0x7F set CGRAM address: target←CGRAM.
  - 0x80–0xFF set DDRAM address: addr←data[6:0], target←DDRAM.
  - 0x00: accepted with no effect.
- **Data writes:**
  - target DDRAM and addr in 0x00–0x0F → write line 0, column addr[3:0].
  - target DDRAM and addr in 0x40–0x4F → write line 1, column addr[3:0].
  - Any other DDRAM address: the write is discarded and no `char_strobe` is issued.
  - Target CGRAM: the data is discarded.
  - In every case above the address counter still steps.
- **Address step** (7 bits, two-line HD44780 map):
  - Increment: 0x27→0x40, 0x67→0x00, otherwise +1.
  - Decrement: 0x00→0x67, 0x40→0x27, otherwise −1.
  - Addresses 0x28–0x3F and 0x68–0x7F step ±1 modulo 128 with no remap.
- **State machine:** IDLE ↔ CLEAR.
  - CLEAR writes 0x20 to character index k (0..31) on cycle k. It returns to IDLE after `CLEAR_CYCLES` cycles.
  - `busy`=1 throughout CLEAR.
  - Any transaction completing during CLEAR is dropped and sets `error`.

## Timing
- **Reset values:** all 32 characters 0x20, addr 0x00, inc 1, target DDRAM, state IDLE, `display_on` 0, `busy` 0, strobes 0, `error` 0.
- **Latency:** transaction detected in cycle T → buffer/addr/flags updated at the edge ending T. `topline`/`bottomline` and the strobes are valid in T+1.
- **Clear latency:** `busy` rises in T+1 and falls in T+1+`CLEAR_CYCLES`. The first accepted transaction may complete in that cycle.
- **Enable:** an enable-high pulse of 1 cycle is a valid transaction. Back-to-back transactions (1 high, 1 low) are all accepted.
- **Enable held high:** no transaction occurs until the falling edge.
- **`reset` mid-transaction:** reset wins over everything. `enable_q` is cleared, so a fall in the cycle after reset is not a transaction.
- **Reset during CLEAR:** aborts the clear and forces the full reset image.

## Structure
- **Package `lcd_bus_pkg`:**
  - Command opcode masks.
  - DDRAM line bases 0x00/0x40 and wrap limits 0x27/0x67.
  - Space char 0x20, `LCD_COLS`=16.
  - State enum IDLE/CLEAR.
- **Sub-module `lcd_char_buffer`:**
  - 32×8 storage with one write port (index, byte, we).
  - Synchronous reset-to-space.
  - Flattened `topline`/`bottomline` outputs.
- **Top:** sampling, decode, address step and FSM live in `lcd_bus_capture`.

## Test plan
- Reset, then write 0x80 followed by "Welcome to Simon", then 0xC0 followed by "Press GRN button" → `topline`/`bottomline` equal those literals. Expect 16 `char_strobe` pulses per line and 2 `cmd_strobe` pulses, `error`=0.
- Write 0x01, then immediately write 0x80 while `busy` → `error`=1 and the second transaction is dropped. `busy` stays high for exactly 32 cycles, after which both lines read all 0x20.
- Write 0xA7, then data 'A','B' (inc) → no strobe for 'A' (addr 0x27, discarded). 'B' lands at line 1, column 0.
- Write 0x04 (decrement), 0x80, then data 'X','Y' → 'X' at line 0 col 0. Addr wraps to 0x67, so 'Y' is discarded.
- Write 0x40, then data 0x55 → image unchanged. A following 0x0C sets `display_on`=1.
- Transaction with `lcd_read`=1, and 0x05 (shift) → `error`=1 and stays 1 until `reset`. Assert `reset` mid-enable → all outputs return to their reset values.
